// File: rtl/digital_clock.sv
// 24-hour BCD time-of-day counter: a programmable prescaler makes a one-cycle
// per-second strobe that advances six HH:MM:SS BCD digits.
module digital_clock (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] clock_frequency,
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic [3:0]  hour_ones,
  output logic [3:0]  hour_tens
);

  logic [31:0] div_cnt_q, div_cnt_d;
  logic [31:0] terminal_s;
  logic        one_sec_pulse;
  logic        pulse_d;
  logic [3:0]  sec_ones_q, sec_ones_d;
  logic [3:0]  sec_tens_q, sec_tens_d;
  logic [3:0]  min_ones_q, min_ones_d;
  logic [3:0]  min_tens_q, min_tens_d;
  logic [3:0]  hour_ones_q, hour_ones_d;
  logic [3:0]  hour_tens_q, hour_tens_d;

  // Prescaler next state; >= lets a lowered divisor end the current second at once
  always_comb begin
    terminal_s = 32'd0;
    div_cnt_d  = 32'd0;
    pulse_d    = 1'b0;
    if (clock_frequency > 32'd1) begin
      terminal_s = clock_frequency - 32'd1;
    end else begin
      terminal_s = 32'd0;
    end
    if (div_cnt_q >= terminal_s) begin
      div_cnt_d = 32'd0;
      pulse_d   = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 32'd1;
      pulse_d   = 1'b0;
    end
  end

  // BCD carry chain, fully resolved in one cycle
  always_comb begin
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    hour_ones_d = hour_ones_q;
    hour_tens_d = hour_tens_q;
    if (one_sec_pulse) begin
      if (sec_ones_q == 4'd9) begin
        sec_ones_d = 4'd0;
        if (sec_tens_q == 4'd5) begin
          sec_tens_d = 4'd0;
          if (min_ones_q == 4'd9) begin
            min_ones_d = 4'd0;
            if (min_tens_q == 4'd5) begin
              min_tens_d = 4'd0;
              if ((hour_tens_q == 4'd2) && (hour_ones_q == 4'd3)) begin
                hour_tens_d = 4'd0;
                hour_ones_d = 4'd0;
              end else if (hour_ones_q == 4'd9) begin
                hour_ones_d = 4'd0;
                hour_tens_d = hour_tens_q + 4'd1;
              end else begin
                hour_ones_d = hour_ones_q + 4'd1;
              end
            end else begin
              min_tens_d = min_tens_q + 4'd1;
            end
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end else begin
          sec_tens_d = sec_tens_q + 4'd1;
        end
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end else begin
      sec_ones_d = sec_ones_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q     <= 32'd0;
      one_sec_pulse <= 1'b0;
      sec_ones_q    <= 4'd0;
      sec_tens_q    <= 4'd0;
      min_ones_q    <= 4'd0;
      min_tens_q    <= 4'd0;
      hour_ones_q   <= 4'd0;
      hour_tens_q   <= 4'd0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      one_sec_pulse <= pulse_d;
      sec_ones_q    <= sec_ones_d;
      sec_tens_q    <= sec_tens_d;
      min_ones_q    <= min_ones_d;
      min_tens_q    <= min_tens_d;
      hour_ones_q   <= hour_ones_d;
      hour_tens_q   <= hour_tens_d;
    end
  end

  assign sec_ones  = sec_ones_q;
  assign sec_tens  = sec_tens_q;
  assign min_ones  = min_ones_q;
  assign min_tens  = min_tens_q;
  assign hour_ones = hour_ones_q;
  assign hour_tens = hour_tens_q;

endmodule

// File: tb/tb_digital_clock.sv
// Randomized self-checking bench for digital_clock against a seconds-count model.
module tb_digital_clock;

  logic        clk;
  logic        reset;
  logic [31:0] clock_frequency;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;

  int total = 0;
  int bad   = 0;

  // model state: edges since release, edge of last pulse, elapsed seconds
  longint k_m, last_m, secs_m;
  logic   exp_pulse_m;

  digital_clock dut (
    .clk(clk), .reset(reset), .clock_frequency(clock_frequency),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hour_ones(hour_ones), .hour_tens(hour_tens)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] time_digits(input longint s);
    longint t, h, m, sc;
    t  = s % 86400;
    h  = t / 3600;
    m  = (t / 60) % 60;
    sc = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic logic [23:0] dut_digits();
    return {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic model_reset();
    k_m = 0; last_m = 0; secs_m = 0; exp_pulse_m = 1'b0;
  endtask

  // Advance one clock edge; model: a second ends once N cycles have passed since the last one
  task automatic advance();
    longint n;
    @(posedge clk);
    @(negedge clk);
    if (exp_pulse_m) secs_m = secs_m + 1;
    k_m = k_m + 1;
    n = (clock_frequency == 32'd0) ? 1 : longint'(clock_frequency);
    exp_pulse_m = ((k_m - last_m) >= n);
    if (exp_pulse_m) last_m = k_m;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b0;
    #200;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    int n;
    n = $urandom_range(12, 2);
    clock_frequency = 32'(n);
    @(negedge clk);
    reset = 1'b0;
    #3;
    total++;
    if (dut_digits() !== 24'h0 || dut.one_sec_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: digits=%h pulse=%b required digits=000000 pulse=0", dut_digits(), dut.one_sec_pulse);
    end
    #200;
    total++;
    if (dut_digits() !== 24'h0) begin
      bad++;
      $display("FAIL reset_hold_late: digits=%h required 000000", dut_digits());
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 6 * n; i++) begin
      advance();
      total++;
      if (dut.one_sec_pulse !== exp_pulse_m || dut_digits() !== time_digits(secs_m)) begin
        bad++;
        $display("FAIL reset_release edge=%0d: pulse=%b digits=%h required pulse=%b digits=%h",
                 k_m, dut.one_sec_pulse, dut_digits(), exp_pulse_m, time_digits(secs_m));
      end
    end
    total++;
    if (secs_m != 6 - 1) begin
      bad++;
      $display("FAIL reset_second_count: model secs=%0d required 5", secs_m);
    end
  endtask

  task automatic test_pulse_spacing();
    int     n;
    longint prev_rise;
    n = $urandom_range(400, 50);
    clock_frequency = 32'(n);
    hold_reset();
    prev_rise = 0;
    for (int i = 0; i < 5 * n; i++) begin
      advance();
      total++;
      if (dut.one_sec_pulse !== exp_pulse_m || dut_digits() !== time_digits(secs_m)) begin
        bad++;
        $display("FAIL spacing edge=%0d: pulse=%b digits=%h required pulse=%b digits=%h",
                 k_m, dut.one_sec_pulse, dut_digits(), exp_pulse_m, time_digits(secs_m));
      end
      if (dut.one_sec_pulse === 1'b1) begin
        total++;
        if (k_m - prev_rise != longint'(n)) begin
          bad++;
          $display("FAIL spacing_period: got %0d cycles required %0d", k_m - prev_rise, n);
        end
        prev_rise = k_m;
      end
    end
  endtask

  task automatic test_runtime_change();
    int n1, m, n2;
    n1 = $urandom_range(20, 8);
    m  = $urandom_range(n1 - 2, n1 / 2);
    n2 = $urandom_range(m, 1);
    clock_frequency = 32'(n1);
    hold_reset();
    for (int i = 0; i < m; i++) advance();
    clock_frequency = 32'(n2);
    for (int i = 0; i < 4 * n2 + 2; i++) begin
      advance();
      total++;
      if (dut.one_sec_pulse !== exp_pulse_m || dut_digits() !== time_digits(secs_m)) begin
        bad++;
        $display("FAIL runtime_change n1=%0d m=%0d n2=%0d edge=%0d: pulse=%b digits=%h required pulse=%b digits=%h",
                 n1, m, n2, k_m, dut.one_sec_pulse, dut_digits(), exp_pulse_m, time_digits(secs_m));
      end
    end
  endtask

  task automatic test_day_wrap();
    int errs;
    clock_frequency = 32'($urandom_range(1, 0));
    hold_reset();
    errs = 0;
    for (int i = 0; i < 86403; i++) begin
      advance();
      total++;
      if (dut.one_sec_pulse !== exp_pulse_m || dut_digits() !== time_digits(secs_m)) begin
        bad++;
        errs++;
        if (errs <= 20)
          $display("FAIL day_wrap edge=%0d: pulse=%b digits=%h required pulse=%b digits=%h",
                   k_m, dut.one_sec_pulse, dut_digits(), exp_pulse_m, time_digits(secs_m));
      end
    end
  endtask

  task automatic test_mid_reset();
    int run, n;
    clock_frequency = 32'd1;
    hold_reset();
    run = $urandom_range(3000, 100);
    for (int i = 0; i < run; i++) advance();
    total++;
    if (dut_digits() !== time_digits(secs_m)) begin
      bad++;
      $display("FAIL mid_reset_pre: digits=%h required %h", dut_digits(), time_digits(secs_m));
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (dut_digits() !== 24'h0 || dut.one_sec_pulse !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async: digits=%h pulse=%b required 000000 0", dut_digits(), dut.one_sec_pulse);
    end
    n = $urandom_range(8, 2);
    clock_frequency = 32'(n);
    #100;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3 * n + 1; i++) begin
      advance();
      total++;
      if (dut.one_sec_pulse !== exp_pulse_m || dut_digits() !== time_digits(secs_m)) begin
        bad++;
        $display("FAIL mid_reset_restart edge=%0d: pulse=%b digits=%h required pulse=%b digits=%h",
                 k_m, dut.one_sec_pulse, dut_digits(), exp_pulse_m, time_digits(secs_m));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    clock_frequency = 32'd4;
    model_reset();
    #20;
    test_reset();
    test_pulse_spacing();
    test_runtime_change();
    test_day_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
